// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan driver: active-low segment codes
// for the ten decimal digits, the blank and dash patterns, and the BCD to
// segment conversion function used by the encoder.
// Segment bit order is {a,b,c,d,e,f,g}, bit 6 = a. A 0 lights a segment.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Non-decimal nibbles (10..15) show a dash so bad data is visible.
    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_to_seg7_enc.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7_enc
// Purely combinational BCD nibble to active-low 7-segment encoder.
// Ports:
//   bcd  in  4  BCD nibble (10..15 encode as a dash)
//   seg  out 7  segments {a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7_enc
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Segment lookup through the shared package function.
    always_comb begin
        seg = bcd_to_seg7(bcd);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A BCD word is accepted over valid/ready into a pending register and moved
// into the display register only at a frame boundary, so a single frame never
// mixes old and new digits. One digit is enabled per slot of REFRESH_DIV clocks.
// Ports:
//   clk         in   1             system clock
//   rst         in   1             synchronous reset, active-high
//   load_valid  in   1             load_bcd valid this cycle
//   load_ready  out  1             driver can accept a new word
//   load_bcd    in   4*NUM_DIGITS  packed BCD, nibble k = digit k
//   blank_lz    in   1             enable leading-zero blanking
//   seg         out  7             segments {a..g}, active-low
//   an          out  NUM_DIGITS    digit enables, active-low
//   frame_tick  out  1             one-cycle pulse at each frame wrap
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] pend_word_q, pend_word_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    load_ready_q, load_ready_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic                    accept_s;
    logic [3:0]              sel_nibble_s;
    logic [6:0]              enc_seg_s;
    logic [NUM_DIGITS-1:0]   blank_mask_s;
    logic                    zero_above_s;
    logic                    blank_sel_s;

    bcd_to_seg7_enc u_enc (
        .bcd (sel_nibble_s),
        .seg (enc_seg_s)
    );

    // Slot timing, digit index and frame boundary detection.
    always_comb begin
        slot_end_s  = (prescaler_q == PRESC_LAST);
        frame_end_s = slot_end_s && (idx_q == IDX_LAST);

        if (slot_end_s) begin
            prescaler_d = '0;
        end else begin
            prescaler_d = prescaler_q + PRESC_W'(1);
        end

        if (!slot_end_s) begin
            idx_d = idx_q;
        end else if (idx_q == IDX_LAST) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Handshake and pending/display transfer. The boundary transfer looks at
    // the pending flag from before this cycle, so a word accepted on the
    // boundary cycle itself waits for the following frame.
    always_comb begin
        accept_s    = load_valid & ~pending_q;
        pending_d   = pending_q;
        pend_word_d = pend_word_q;
        disp_d      = disp_q;

        if (frame_end_s && pending_q) begin
            disp_d    = pend_word_q;
            pending_d = 1'b0;
        end else begin
            disp_d    = disp_q;
        end

        if (accept_s) begin
            pend_word_d = load_bcd;
            pending_d   = 1'b1;
        end else begin
            pend_word_d = pend_word_q;
        end

        load_ready_d = ~pending_d;
        frame_tick_d = frame_end_s;
    end

    // Leading-zero mask: digit k is blankable when it and every more
    // significant digit are zero; digit 0 is never blanked.
    always_comb begin
        zero_above_s = 1'b1;
        blank_mask_s = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above_s    = zero_above_s & (disp_q[4*k +: 4] == 4'd0);
            blank_mask_s[k] = zero_above_s;
        end
    end

    // Digit select and output encoding for the current slot.
    always_comb begin
        sel_nibble_s = disp_q[4*idx_q +: 4];
        blank_sel_s  = blank_lz & blank_mask_s[idx_q];

        if (blank_sel_s) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
        end else begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = enc_seg_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            pend_word_q  <= '0;
            disp_q       <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            load_ready_q <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_word_q  <= pend_word_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            load_ready_q <= load_ready_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign load_ready = load_ready_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed plus randomized bench for seg7_scan_driver (4 digits, 4 clocks per
// slot). A cycle-counting reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int FRM = N * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [4*N-1:0] load_bcd;
    logic          blank_lz;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          frame_tick;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int            cnt;
    logic          m_pending;
    logic [15:0]   m_pend;
    logic [15:0]   m_disp;
    logic [6:0]    exp_seg;
    logic [N-1:0]  exp_an;
    logic          exp_ready;
    logic          exp_tick;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_bcd   (load_bcd),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] code_of(input int n);
        case (n)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    // Model advanced by one clock edge using the inputs present at that edge.
    // Time is tracked as a count of clocks since reset release: the digit in
    // view is (count / DIV) mod N and a frame ends every FRM clocks.
    task automatic model_edge();
        int  idx;
        int  nib;
        bit  blanked;
        bit  boundary;
        bit  acc;
        if (rst) begin
            cnt = 0; m_pending = 1'b0; m_pend = '0; m_disp = '0;
            exp_seg = 7'b1111111; exp_an = '1; exp_ready = 1'b1; exp_tick = 1'b0;
        end else begin
            idx      = (cnt / DIV) % N;
            nib      = int'((m_disp >> (4 * idx)) & 16'hF);
            blanked  = blank_lz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
            exp_an   = blanked ? {N{1'b1}} : N'(~(32'd1 << idx));
            exp_seg  = blanked ? 7'b1111111 : code_of(nib);
            boundary = (cnt % FRM) == (FRM - 1);
            exp_tick = boundary;
            acc      = load_valid && !m_pending;
            if (boundary && m_pending) begin
                m_disp    = m_pend;
                m_pending = 1'b0;
            end
            if (acc) begin
                m_pend    = load_bcd;
                m_pending = 1'b1;
            end
            exp_ready = !m_pending;
            cnt++;
        end
    endtask

    task automatic check_outputs();
        vectors++;
        assert (seg === exp_seg) else begin
            miscompares++;
            $error("FAIL seg: observed %b expected %b (t=%0t)", seg, exp_seg, $time);
        end
        assert (an === exp_an) else begin
            miscompares++;
            $error("FAIL an: observed %b expected %b (t=%0t)", an, exp_an, $time);
        end
        assert (load_ready === exp_ready) else begin
            miscompares++;
            $error("FAIL load_ready: observed %b expected %b (t=%0t)", load_ready, exp_ready, $time);
        end
        assert (frame_tick === exp_tick) else begin
            miscompares++;
            $error("FAIL frame_tick: observed %b expected %b (t=%0t)", frame_tick, exp_tick, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle offer of a word.
    task automatic offer(input logic [15:0] w);
        load_valid = 1'b1;
        load_bcd   = w;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_bcd = '0; blank_lz = 1'b0;
        cnt = 0; m_pending = 1'b0; m_pend = '0; m_disp = '0;

        // 1. Reset held three cycles, then the first scan of an all-zero display
        run(3);
        assert (seg === 7'b1111111 && an === 4'b1111 && load_ready === 1'b1) else begin
            miscompares++;
            $error("FAIL reset_state: observed seg=%b an=%b rdy=%b expected 1111111/1111/1", seg, an, load_ready);
        end
        rst = 1'b0;
        run(2);
        vectors++;
        assert (seg === 7'b0000001 && an === 4'b1110) else begin
            miscompares++;
            $error("FAIL first_scan: observed seg=%b an=%b expected 0000001/1110", seg, an);
        end

        // 2. Load 1234 without blanking; ready drops after accept
        offer(16'h1234);
        vectors++;
        assert (load_ready === 1'b0) else begin
            miscompares++;
            $error("FAIL ready_drop: observed %b expected 0", load_ready);
        end
        run(2 * FRM);

        // 3. Load 5678, then offer 9999 while not ready (must be dropped)
        offer(16'h5678);
        load_valid = 1'b1; load_bcd = 16'h9999;
        run(2);
        load_valid = 1'b0;
        run(2 * FRM);
        vectors++;
        assert (m_disp === 16'h5678) else begin
            miscompares++;
            $error("FAIL drop_busy: observed model display %h expected 5678", m_disp);
        end

        // 4. Leading-zero blanking on 0070 and 0000
        blank_lz = 1'b1;
        offer(16'h0070);
        run(2 * FRM);
        offer(16'h0000);
        run(2 * FRM);

        // 5. Non-decimal nibbles show a dash
        offer(16'h00AF);
        run(2 * FRM);
        blank_lz = 1'b0;
        run(FRM);

        // 6a. Accept on the exact boundary cycle: applied one frame later
        for (int i = 0; i < FRM && (cnt % FRM) != (FRM - 1); i++) step();
        offer(16'h4321);
        vectors++;
        assert (frame_tick === 1'b1 && load_ready === 1'b0) else begin
            miscompares++;
            $error("FAIL boundary_accept: observed tick=%b rdy=%b expected 1/0", frame_tick, load_ready);
        end
        run(2 * FRM);

        // 6b. Reset with a word pending discards it
        offer(16'h8765);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        assert (load_ready === 1'b1 && seg === 7'b1111111) else begin
            miscompares++;
            $error("FAIL reset_pending: observed rdy=%b seg=%b expected 1/1111111", load_ready, seg);
        end
        run(2 * FRM);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_bcd   = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                load_bcd[15:8] = 8'h00;
            end
            if ($urandom_range(0, 63) == 0) begin
                blank_lz = ~blank_lz;
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; load_valid = 1'b0;
        run(FRM);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
